multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multicycle MIPS-subset datapath. Sequences the program counter, instruction register, register file, ALU and unified memory: issues the PC write enable and next-PC select, and stalls on a memory-ready handshake. Sits beside the program counter, which latches `nextAddress` when `pcEn` is high.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `op` in 6: instruction opcode, IR[31:26].
- `funct` in 6: R-type function field, IR[5:0].
- `zero` in 1: ALU zero flag.
- `memReady` in 1: memory completes the current access this cycle.
- `pcEn` out 1: program counter load enable.
- `pcSrc` out 2: next-PC mux select.
  - 00: ALU result.
  - 01: ALUOut register.
  - 10: jump target.
- `iOrD` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memWrite` out 1: memory write strobe.
- `irWrite` out 1: instruction register load.
- `regDst` out 1: write register select (0 = rt, 1 = rd).
- `memToReg` out 1: write-back select (1 = memory data).
- `regWrite` out 1: register file write.
- `aluSrcA` out 1: ALU A select (0 = PC, 1 = A register).
- `aluSrcB` out 2: ALU B select.
  - 00: B register.
  - 01: constant 4.
  - 10: sign-extended immediate.
  - 11: shifted immediate.
- `aluControl` out 3: ALU operation code.
- `illegalOp` out 1: unsupported opcode or funct seen.
- `state` out 4: current state, for debug.

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- Internal `aluOp`:
  - 00 gives add, `aluControl` 010.
  - 01 gives sub, `aluControl` 110.
  - 10 decodes `funct`:
    - add 100000 → 010
    - sub 100010 → 110
    - and 100100 → 000
    - or 100101 → 001
    - slt 101010 → 111
    - any other funct → 010, with `illegalOp` = 1.
- Outputs are a Moore decode of `state`, except `pcEn`, `irWrite` and the stall exits, which also depend on `zero` and `memReady`. Any output not listed for a state is 0.
- States (encoding: transitions → settings):
  - FETCH (0): → DECODE when `memReady`, else stay. `iOrD`=0, `aluSrcA`=0, `aluSrcB`=01, add, `pcSrc`=00, `irWrite`=`pcEn`=`memReady`.
  - DECODE (1): → MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq, ADDIEX for addi, JUMP for j. `aluSrcA`=0, `aluSrcB`=11, add.
  - DECODE with any other opcode: `illegalOp`=1, → FETCH.
  - MEMADR (2): → MEMRD for lw, MEMWR for sw. `aluSrcA`=1, `aluSrcB`=10, add.
  - MEMRD (3): → MEMWB when `memReady`, else stay. `iOrD`=1.
  - MEMWB (4): → FETCH. `regDst`=0, `memToReg`=1, `regWrite`=1.
  - MEMWR (5): → FETCH when `memReady`, else stay. `iOrD`=1, `memWrite`=1, held until the exit edge.
  - EXECUTE (6): → ALUWB. `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10.
  - ALUWB (7): → FETCH. `regDst`=1, `regWrite`=1, except `regWrite`=0 if `funct` is unsupported.
  - BRANCH (8): → FETCH. `aluSrcA`=1, `aluSrcB`=00, sub, `pcSrc`=01, `pcEn`=`zero`.
  - ADDIEX (9): → ADDIWB. `aluSrcA`=1, `aluSrcB`=10, add.
  - ADDIWB (10): → FETCH. `regDst`=0, `regWrite`=1.
  - JUMP (11): → FETCH. `pcSrc`=10, `pcEn`=1.
  - Encodings 12–15: → FETCH on the next edge, all outputs 0.
- `op` and `funct` are sampled from the IR, which is stable after FETCH. The controller holds no copy of them.

## Timing
- Reset state:
  - While `rst` = 0: `state` = FETCH, and all write strobes (`pcEn`, `irWrite`, `regWrite`, `memWrite`) are forced to 0.
  - All other outputs take their FETCH values.
- Reset asserted mid-instruction: abandons the instruction immediately, with no partial write after reset assertion. First fetch occurs on the first edge after `rst` rises with `memReady` = 1.
- Latency with `memReady` held at 1, in cycles:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle of `memReady` = 0 in FETCH, MEMRD or MEMWR adds one cycle. In those cycles `pcEn`, `irWrite` and `regWrite` stay 0.
- The PC advances exactly once per FETCH (`pcEn` high for a single cycle), plus at most once in BRANCH or JUMP.

## Structure
- Package `mc_pkg`:
  - state encodings
  - opcode and funct constants
  - `aluControl` codes
  - `aluSrcB` and `pcSrc` select codes
- Sub-module `alu_decoder`: (`aluOp`, `funct`) → (`aluControl`, `funct` illegal flag), purely combinational.
- Top level: state register, next-state logic, output decode.

## Test plan
- **Reset:** hold `rst` = 0 with `memReady` = 1 for 3 cycles → `state` = 0, `pcEn` = `irWrite` = `regWrite` = `memWrite` = 0. Release → `pcEn` pulses on the first edge.
- **lw with wait states:** `op` = 100011, `memReady` low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. `regWrite` = 1 only in state 4, with `memToReg` = 1.
- **beq:** `op` = 000100 with `zero` = 1 → `pcEn` = 1 and `pcSrc` = 01 in state 8. Repeat with `zero` = 0 → no `pcEn` in state 8.
- **R-type:** `op` = 0, `funct` = 101010 → `aluControl` = 111 in state 6, `regDst` = 1 and `regWrite` = 1 in state 7. Repeat with `funct` = 111111 → `illegalOp` = 1 and no `regWrite`.
- **Jump and illegal opcode:** `op` = 000010 → `pcSrc` = 10 and `pcEn` = 1 in state 11, then FETCH. `op` = 111111 → `illegalOp` = 1 in DECODE, then return to FETCH with no strobes.
- **Reset during MEMWR:** `op` = 101011, drop `rst` while in state 5 → `memWrite` falls within the same cycle and `state` = 0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller (states, opcodes, funct codes, mux selects)
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps aluOp and the R-type funct field to an ALU control code
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_bad_o
);
  logic [2:0] f_ctl;
  // funct lookup; unsupported codes fall back to add and raise the flag
  always_comb begin
    f_ctl = ALU_ADD;
    funct_bad_o = 1'b0;
    case (funct_i)
      F_ADD:   f_ctl = ALU_ADD;
      F_SUB:   f_ctl = ALU_SUB;
      F_AND:   f_ctl = ALU_AND;
      F_OR:    f_ctl = ALU_OR;
      F_SLT:   f_ctl = ALU_SLT;
      default: funct_bad_o = 1'b1;
    endcase
  end
  assign alu_control_o = (alu_op_i == ALUOP_FUNCT) ? f_ctl :
                         (alu_op_i == ALUOP_SUB)   ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing PC, IR, register file, ALU and memory
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcEn,
  output logic [1:0] pcSrc,
  output logic       iOrD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic       illegalOp,
  output logic [3:0] state
);
  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       funct_bad, op_bad;
  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (funct),
    .alu_control_o (aluControl),
    .funct_bad_o   (funct_bad)
  );
  assign op_bad = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  assign state  = state_q;
  // state register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end
  // next state; memory states stall until memReady
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE:  case (op)
                   OP_LW, OP_SW: state_d = S_MEMADR;
                   OP_RTYPE:     state_d = S_EXECUTE;
                   OP_BEQ:       state_d = S_BRANCH;
                   OP_ADDI:      state_d = S_ADDIEX;
                   OP_J:         state_d = S_JUMP;
                   default:      state_d = S_FETCH;
                 endcase
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = memReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end
  // output decode; write strobes are gated by reset so they drop the moment it asserts
  always_comb begin
    pcEn      = 1'b0;
    pcSrc     = PC_ALU;
    iOrD      = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_B;
    alu_op    = ALUOP_ADD;
    illegalOp = 1'b0;
    case (state_q)
      S_FETCH:   begin aluSrcB = SRCB_4; irWrite = memReady; pcEn = memReady; end
      S_DECODE:  begin aluSrcB = SRCB_SHIMM; illegalOp = op_bad; end
      S_MEMADR:  begin aluSrcA = 1'b1; aluSrcB = SRCB_IMM; end
      S_MEMRD:   iOrD = 1'b1;
      S_MEMWB:   begin memToReg = 1'b1; regWrite = 1'b1; end
      S_MEMWR:   begin iOrD = 1'b1; memWrite = 1'b1; end
      S_EXECUTE: begin aluSrcA = 1'b1; alu_op = ALUOP_FUNCT; illegalOp = funct_bad; end
      S_ALUWB:   begin regDst = 1'b1; regWrite = !funct_bad; end
      S_BRANCH:  begin aluSrcA = 1'b1; alu_op = ALUOP_SUB; pcSrc = PC_ALUOUT; pcEn = zero; end
      S_ADDIEX:  begin aluSrcA = 1'b1; aluSrcB = SRCB_IMM; end
      S_ADDIWB:  regWrite = 1'b1;
      S_JUMP:    begin pcSrc = PC_JUMP; pcEn = 1'b1; end
      default:   ;
    endcase
    {pcEn, irWrite, regWrite, memWrite} = {pcEn, irWrite, regWrite, memWrite} & {4{rst}};
  end
endmodule
